// File: rtl/half_adder_bist.sv
`default_nettype none
// ============================================================================
//  Module      : half_adder_bist
//  Description : Built-in self-test controller for a half-adder cell. Walks
//                the cell through vectors 00,01,10,11 for LOOPS passes, holds
//                each vector SETTLE_CYCLES cycles, then checks SUM/CARRY
//                against the golden function and reports pass/fail, a
//                saturating error count and the first failing vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module half_adder_bist #(
   parameter int SETTLE_CYCLES = 1,
   parameter int LOOPS         = 1,
   parameter int CNT_W         = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             ABORT,
   output logic             HA_A,
   output logic             HA_B,
   input  logic             HA_SUM,
   input  logic             HA_CARRY,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic             FAIL_VALID,
   output logic [1:0]       FAIL_VEC,
   output logic [CNT_W-1:0] ERR_COUNT
);

   // Settle counter must hold the value SETTLE_CYCLES; loop counter must
   // hold LOOPS-1 (at least one bit in both cases).
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int LOOP_W = (LOOPS < 2) ? 1 : $clog2(LOOPS);

   localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
   localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);
   localparam logic [CNT_W-1:0]  ERR_MAX     = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      REPORT = 2'd3
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [SET_W-1:0]   settle_cnt;
   logic [LOOP_W-1:0]  loop_cnt;

   // Event decodes shared by the FSM and the datapath.
   logic               start_ok;
   logic               do_start;
   logic               do_abort;
   logic               do_check;
   logic               last_check;
   logic               mismatch;
   logic [1:0]         cur_vec;
   logic [1:0]         nxt_vec;

   assign cur_vec = {HA_A, HA_B};
   assign nxt_vec = cur_vec + 2'd1;

   // Decode run events and compare the cell response with the golden
   // half-adder; either bit wrong is a single mismatch for the vector.
   always_comb begin
      start_ok   = START & ~ABORT;
      do_start   = (state == IDLE) & start_ok;
      do_abort   = ((state == SETTLE) | (state == CHECK)) & ABORT;
      do_check   = (state == CHECK) & ~ABORT;
      last_check = (cur_vec == 2'b11) & (loop_cnt == LOOP_LAST);
      mismatch   = (HA_SUM != (HA_A ^ HA_B)) | (HA_CARRY != (HA_A & HA_B));
   end

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; ABORT only acts while a run is in flight.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start_ok) begin
               next_state = SETTLE;
            end
         end
         SETTLE: begin
            if (ABORT) begin
               next_state = IDLE;
            end else if (settle_cnt <= SET_W'(1)) begin
               next_state = CHECK;
            end
         end
         CHECK: begin
            if (ABORT) begin
               next_state = IDLE;
            end else if (last_check) begin
               next_state = REPORT;
            end else begin
               next_state = SETTLE;
            end
         end
         REPORT: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Registered status flags follow the state that is being entered, so
   // they change on the same edge as the state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         BUSY <= 1'b0;
         DONE <= 1'b0;
      end else begin
         BUSY <= (next_state == SETTLE) | (next_state == CHECK);
         DONE <= (next_state == REPORT);
      end
   end

   // Vector sequencing, settle/loop counting and result accumulation.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         HA_A       <= 1'b0;
         HA_B       <= 1'b0;
         settle_cnt <= '0;
         loop_cnt   <= '0;
         PASS       <= 1'b0;
         FAIL_VALID <= 1'b0;
         FAIL_VEC   <= 2'b00;
         ERR_COUNT  <= '0;
      end else if (do_start) begin
         HA_A       <= 1'b0;
         HA_B       <= 1'b0;
         settle_cnt <= SETTLE_LOAD;
         loop_cnt   <= '0;
         PASS       <= 1'b0;
         FAIL_VALID <= 1'b0;
         FAIL_VEC   <= 2'b00;
         ERR_COUNT  <= '0;
      end else if (do_abort) begin
         // Error history of the aborted run is kept for inspection.
         HA_A       <= 1'b0;
         HA_B       <= 1'b0;
         settle_cnt <= '0;
         loop_cnt   <= '0;
         PASS       <= 1'b0;
      end else if (state == SETTLE) begin
         settle_cnt <= settle_cnt - SET_W'(1);
      end else if (do_check) begin
         if (mismatch) begin
            if (ERR_COUNT != ERR_MAX) begin
               ERR_COUNT <= ERR_COUNT + CNT_W'(1);
            end
            if (!FAIL_VALID) begin
               FAIL_VALID <= 1'b1;
               FAIL_VEC   <= cur_vec;
            end
         end
         if (last_check) begin
            HA_A       <= 1'b0;
            HA_B       <= 1'b0;
            settle_cnt <= '0;
            loop_cnt   <= '0;
            PASS       <= ~FAIL_VALID & ~mismatch;
         end else begin
            HA_A       <= nxt_vec[1];
            HA_B       <= nxt_vec[0];
            settle_cnt <= SETTLE_LOAD;
            if (cur_vec == 2'b11) begin
               loop_cnt <= loop_cnt + LOOP_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_half_adder_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_half_adder_bist
//  Description : Directed self-checking bench for half_adder_bist. Three
//                instances with different parameters drive a behavioural
//                half-adder whose fault mode is selectable per instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_half_adder_bist;

   logic clk;
   logic rst_n;
   logic start0, start1, start2;
   logic abort0, abort1, abort2;
   int   mode0, mode1, mode2;   // 0 good, 1 SUM stuck 0, 2 CARRY stuck 1, 3 both inverted

   logic a0, b0, sum0, carry0, busy0, done0, pass0, fv0;
   logic a1, b1, sum1, carry1, busy1, done1, pass1, fv1;
   logic a2, b2, sum2, carry2, busy2, done2, pass2, fv2;
   logic [1:0] fvec0, fvec1, fvec2;
   logic [7:0] err0, err1;
   logic [1:0] err2;

   int checks;
   int errors;

   function automatic logic cell_sum(input logic a, input logic b, input int m);
      case (m)
         1:       return 1'b0;
         3:       return ~(a ^ b);
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic cell_carry(input logic a, input logic b, input int m);
      case (m)
         2:       return 1'b1;
         3:       return ~(a & b);
         default: return a & b;
      endcase
   endfunction

   assign sum0   = cell_sum(a0, b0, mode0);
   assign carry0 = cell_carry(a0, b0, mode0);
   assign sum1   = cell_sum(a1, b1, mode1);
   assign carry1 = cell_carry(a1, b1, mode1);
   assign sum2   = cell_sum(a2, b2, mode2);
   assign carry2 = cell_carry(a2, b2, mode2);

   half_adder_bist #(.SETTLE_CYCLES(1), .LOOPS(1), .CNT_W(8)) u_dut0 (
      .CLK(clk), .RST_N(rst_n), .START(start0), .ABORT(abort0),
      .HA_A(a0), .HA_B(b0), .HA_SUM(sum0), .HA_CARRY(carry0),
      .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_VALID(fv0),
      .FAIL_VEC(fvec0), .ERR_COUNT(err0)
   );

   half_adder_bist #(.SETTLE_CYCLES(2), .LOOPS(3), .CNT_W(8)) u_dut1 (
      .CLK(clk), .RST_N(rst_n), .START(start1), .ABORT(abort1),
      .HA_A(a1), .HA_B(b1), .HA_SUM(sum1), .HA_CARRY(carry1),
      .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_VALID(fv1),
      .FAIL_VEC(fvec1), .ERR_COUNT(err1)
   );

   half_adder_bist #(.SETTLE_CYCLES(1), .LOOPS(2), .CNT_W(2)) u_dut2 (
      .CLK(clk), .RST_N(rst_n), .START(start2), .ABORT(abort2),
      .HA_A(a2), .HA_B(b2), .HA_SUM(sum2), .HA_CARRY(carry2),
      .BUSY(busy2), .DONE(done2), .PASS(pass2), .FAIL_VALID(fv2),
      .FAIL_VEC(fvec2), .ERR_COUNT(err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic done_of(input int idx);
      case (idx)
         0:       return done0;
         1:       return done1;
         default: return done2;
      endcase
   endfunction

   // Pulse START for one sampling edge; returns 1 ns after that edge (E0).
   task automatic start_run(input int idx);
      @(negedge clk);
      case (idx)
         0:       start0 = 1'b1;
         1:       start1 = 1'b1;
         default: start2 = 1'b1;
      endcase
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   // Observe DONE for a bounded number of cycles; first is the cycle index
   // (edges after the call) of the first DONE, -1 if none was seen.
   task automatic watch_done(input int idx, input int window, output int first, output int n);
      first = -1;
      n     = 0;
      for (int c = 1; c <= window; c++) begin
         @(posedge clk);
         #1;
         if (done_of(idx) === 1'b1) begin
            n++;
            if (first < 0) first = c;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int first;
      int n;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      abort0 = 1'b0; abort1 = 1'b0; abort2 = 1'b0;
      mode0  = 0;    mode1  = 0;    mode2  = 0;

      // Reset state
      #12;
      check_value("rst_ha",   {a0, b0}, 2'b00);
      check_value("rst_busy", busy0, 1'b0);
      check_value("rst_done", done0, 1'b0);
      check_value("rst_pass", pass0, 1'b0);
      check_value("rst_fv",   fv0, 1'b0);
      check_value("rst_fvec", fvec0, 2'b00);
      check_value("rst_err",  err0, 0);
      check_value("rst_err2", err2, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Clean run: vector sequence, 2 cycles per vector, DONE after edge E0+8
      mode0 = 0;
      start_run(0);
      for (int k = 0; k < 8; k++) begin
         check_value("t1_vec",  {a0, b0}, k / 2);
         check_value("t1_busy", busy0, 1'b1);
         check_value("t1_done", done0, 1'b0);
         @(posedge clk);
         #1;
      end
      check_value("t1_done_hi", done0, 1'b1);
      check_value("t1_busy_lo", busy0, 1'b0);
      check_value("t1_ha_end",  {a0, b0}, 2'b00);
      check_value("t1_pass",    pass0, 1'b1);
      check_value("t1_err",     err0, 0);
      check_value("t1_fv",      fv0, 1'b0);
      @(posedge clk);
      #1;
      check_value("t1_done_lo",  done0, 1'b0);
      check_value("t1_pass_hold", pass0, 1'b1);

      // SUM stuck at 0: vectors 01 and 10 fail
      mode0 = 1;
      start_run(0);
      watch_done(0, 12, first, n);
      check_value("t2_done_cyc", first, 8);
      check_value("t2_done_cnt", n, 1);
      check_value("t2_err",  err0, 2);
      check_value("t2_fvec", fvec0, 2'b01);
      check_value("t2_fv",   fv0, 1'b1);
      check_value("t2_pass", pass0, 1'b0);

      // CARRY stuck at 1, 3 loops, settle 2: 00/01/10 fail each loop
      mode1 = 2;
      start_run(1);
      watch_done(1, 40, first, n);
      check_value("t3_done_cyc", first, 36);
      check_value("t3_done_cnt", n, 1);
      check_value("t3_err",  err1, 9);
      check_value("t3_fvec", fvec1, 2'b00);
      check_value("t3_pass", pass1, 1'b0);

      // Both outputs inverted, 2 loops, 2-bit counter saturates at 3
      mode2 = 3;
      start_run(2);
      watch_done(2, 20, first, n);
      check_value("t4_done_cyc", first, 16);
      check_value("t4_err_sat", err2, 2'd3);
      check_value("t4_fvec", fvec2, 2'b00);
      check_value("t4_pass", pass2, 1'b0);

      // ABORT during vector 10 with SUM stuck 0 (01 already failed)
      mode0 = 1;
      start_run(0);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check_value("t5_vec10", {a0, b0}, 2'b10);
      abort0 = 1'b1;
      @(posedge clk);
      #1;
      abort0 = 1'b0;
      check_value("t5_busy", busy0, 1'b0);
      check_value("t5_ha",   {a0, b0}, 2'b00);
      check_value("t5_pass", pass0, 1'b0);
      check_value("t5_err_keep",  err0, 1);
      check_value("t5_fv_keep",   fv0, 1'b1);
      check_value("t5_fvec_keep", fvec0, 2'b01);
      watch_done(0, 12, first, n);
      check_value("t5_no_done", n, 0);
      mode0 = 0;
      start_run(0);
      watch_done(0, 12, first, n);
      check_value("t5_rerun_cyc", first, 8);
      check_value("t5_rerun_pass", pass0, 1'b1);
      check_value("t5_rerun_err", err0, 0);
      check_value("t5_rerun_fv", fv0, 1'b0);

      // START re-pulsed mid-run does not restart the run
      start_run(0);
      repeat (2) @(posedge clk);
      #1;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      watch_done(0, 12, first, n);
      check_value("t6_done_cyc", first, 5);
      check_value("t6_done_cnt", n, 1);
      check_value("t6_pass", pass0, 1'b1);

      // Asynchronous reset mid-run
      start_run(0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_value("t7_busy", busy0, 1'b0);
      check_value("t7_ha",   {a0, b0}, 2'b00);
      check_value("t7_pass", pass0, 1'b0);
      check_value("t7_done", done0, 1'b0);
      check_value("t7_err",  err0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_done(0, 12, first, n);
      check_value("t7_no_done", n, 0);
      check_value("t7_idle", busy0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/half_adder_bist.md
# half_adder_bist

Built-in self-test controller for the `Half_Adder` datapath cell. It drives the cell's `A`/`B` inputs through the exhaustive vector set (00, 01, 10, 11) and samples `SUM`/`CARRY` after a programmable settle time. Each response is compared against the golden half-adder function, and the block reports pass/fail, an error count and the first failing vector. It sits beside each half-adder instance that needs in-system test and is the synthesizable counterpart of the simulation stimulus/monitor.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles a vector is held before its check cycle. Legal range is 1 or more.
- `LOOPS`, default 1: number of full 4-vector passes per run. Legal range is 1 or more.
- `CNT_W`, default 8: width of `ERR_COUNT`.

Ports:
- `CLK`, input, 1: the single clock. All logic is rising-edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `START`, input, 1: starts a run. Sampled in IDLE only.
- `ABORT`, input, 1: terminates a run. Takes priority over `START`.
- `HA_A`, output, 1: drives `A` of the cell under test. Registered.
- `HA_B`, output, 1: drives `B` of the cell under test. Registered.
- `HA_SUM`, input, 1: `SUM` from the cell under test.
- `HA_CARRY`, input, 1: `CARRY` from the cell under test.
- `BUSY`, output, 1: high in SETTLE and CHECK.
- `DONE`, output, 1: one-cycle pulse when a run completes normally.
- `PASS`, output, 1: sticky. High after a completed run with zero errors.
- `FAIL_VALID`, output, 1: sticky. High once any mismatch is seen in the current run.
- `FAIL_VEC`, output, 2: `{A,B}` of the first failing vector in the current run.
- `ERR_COUNT`, output, `CNT_W`: number of mismatching vector checks. Saturating.

## Operation
- States are IDLE, SETTLE, CHECK and REPORT.
- Reset values:
  - State is IDLE.
  - `HA_A`, `HA_B`, `BUSY`, `DONE`, `PASS`, `FAIL_VALID` are 0.
  - `FAIL_VEC` is 00 and `ERR_COUNT` is 0.
  - The vector index, loop counter and settle counter are 0.
- IDLE:
  - `HA_A`/`HA_B` are driven 0.
  - On `START`=1 with `ABORT`=0:
    - load vector 00 into `HA_A`/`HA_B`;
    - clear `PASS`, `FAIL_VALID`, `FAIL_VEC` and `ERR_COUNT`;
    - load the settle counter with `SETTLE_CYCLES`;
    - enter SETTLE.
- SETTLE: the counter decrements each cycle. On the edge where it reaches 0, enter CHECK.
- CHECK (exactly 1 cycle), on the exiting edge:
  - Expected response is `SUM` = `HA_A`^`HA_B` and `CARRY` = `HA_A`&`HA_B`.
  - A mismatch in either bit counts as one error for that vector, never two.
  - On a mismatch, `ERR_COUNT` increments and saturates at 2^`CNT_W`-1.
  - If `FAIL_VALID` was 0, capture `FAIL_VEC` = {`HA_A`,`HA_B`} and set `FAIL_VALID`.
  - Advance the vector in the order 00→01→10→11. After 11 it wraps to 00 and the loop counter increments.
  - If the vector was 11 and the loop counter equals `LOOPS`-1:
    - enter REPORT;
    - set `HA_A`/`HA_B` to 0;
    - set `PASS` = (error-free run, counting the current check);
    - pulse `DONE`.
  - Otherwise, load the next vector and enter SETTLE with a reloaded counter.
- REPORT: `DONE` is 1 for exactly this cycle, then the state returns to IDLE. `START` is ignored here.
- `ABORT`=1 in SETTLE or CHECK:
  - next state is IDLE;
  - `HA_A`/`HA_B` go to 0;
  - no `DONE` and no check on that edge;
  - `PASS` is 0;
  - `ERR_COUNT`, `FAIL_VALID` and `FAIL_VEC` keep their values.
- `ABORT` in IDLE or REPORT has no effect beyond blocking `START`.
- `START` while `BUSY` is ignored and does not restart the run.
- `RST_N` low at any point forces all reset values immediately. An in-flight run is lost and no `DONE` is produced.

## Timing
- Each vector occupies `SETTLE_CYCLES`+1 cycles, and `HA_A`/`HA_B` are stable for the whole period.
- Let E0 be the `START` sampling edge. The final check is at edge E0 + 4·`LOOPS`·(`SETTLE_CYCLES`+1). `DONE` is high for the following cycle.
- The cell under test is sampled directly from `HA_SUM`/`HA_CARRY` at the CHECK-exit edge. The cell's combinational delay must fit within `SETTLE_CYCLES` cycles.
- `BUSY` goes high at E0 and low at the final-check edge.
- The status outputs are registered and update on the same edges as the state changes.

## Test plan
- Correct half adder with `SETTLE_CYCLES`=1 and `LOOPS`=1:
  - `HA_A`/`HA_B` sequence is 00,01,10,11, each held 2 cycles.
  - `DONE` is high in cycle E0+9 (after edge E0+8).
  - `PASS`=1, `ERR_COUNT`=0, `FAIL_VALID`=0.
- `HA_SUM` stuck at 0, `LOOPS`=1: `ERR_COUNT`=2, `FAIL_VEC`=01, `PASS`=0, `DONE` pulses once.
- `HA_CARRY` stuck at 1, `LOOPS`=3, `SETTLE_CYCLES`=2: `ERR_COUNT`=9, `FAIL_VEC`=00, and `DONE` at edge E0+36.
- Both outputs inverted, `CNT_W`=2, `LOOPS`=2: there are 8 mismatches, and `ERR_COUNT` saturates at 3.
- `ABORT` asserted during the third vector (10):
  - `BUSY` falls and `HA_A`/`HA_B` go to 00 on the next edge;
  - no `DONE`; `PASS`=0;
  - a new `START` afterwards completes a clean run with `PASS`=1.
- Interrupt cases:
  - `START` re-pulsed mid-run is ignored, so total run length is unchanged.
  - `RST_N` pulsed low mid-run gives all outputs at reset values asynchronously and no `DONE`.
